// File: rtl/segment_transition_scheduler_pkg.sv
// transition: shared request and channel types for segment_transition_scheduler
package transition;
  typedef enum logic [2:0] {IMMEDIATE, SYNC_IDX, SYS_TIME, GPIO} mode_t;
  typedef enum logic {TGT_MOD, TGT_STM} target_t;
  typedef enum {IDLE, ARMED, ALIGN} ch_state_t;
endpackage

// File: rtl/segment_transition_scheduler_if.sv
// segment_transition_scheduler_if: controller-to-scheduler transition request handshake
interface segment_transition_scheduler_if #(
  parameter int SYS_TIME_W = 64
);
  logic REQ_VALID;
  logic REQ_READY;
  logic REQ_TARGET;
  logic REQ_SEGMENT;
  logic [2:0] REQ_MODE;
  logic [SYS_TIME_W-1:0] REQ_VALUE;
  modport master(output REQ_VALID, REQ_TARGET, REQ_SEGMENT, REQ_MODE, REQ_VALUE, input REQ_READY);
  modport slave(input REQ_VALID, REQ_TARGET, REQ_SEGMENT, REQ_MODE, REQ_VALUE, output REQ_READY);
endinterface

// File: rtl/segment_transition_scheduler_channel.sv
// transition_channel: holds one request per target, evaluates its trigger and swaps on UPDATE
module transition_channel
  import transition::*;
#(
  parameter int SYS_TIME_W = 64,
  parameter int GPIO_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic req_segment,
  input  mode_t req_mode,
  input  logic [SYS_TIME_W-1:0] req_value,
  input  logic [SYS_TIME_W-1:0] sys_time,
  input  logic update,
  input  logic wrap,
  input  logic [GPIO_N-1:0] gpio_rise,
  output logic swap,
  output logic segment,
  output logic pending
);
  ch_state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [SYS_TIME_W-1:0] value_q, value_d;
  logic tgt_q, tgt_d, seg_q, seg_d, swap_q, swap_d;
  logic cond, fire, done;
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    mode_q <= rst ? IMMEDIATE : mode_d;
    value_q <= rst ? '0 : value_d;
    tgt_q <= rst ? 1'b0 : tgt_d;
    seg_q <= rst ? 1'b0 : seg_d;
    swap_q <= rst ? 1'b0 : swap_d;
  end
  always_comb begin
    cond = mode_q == IMMEDIATE || (mode_q == SYNC_IDX && wrap) ||
           (mode_q == SYS_TIME && sys_time >= value_q) ||
           (mode_q == GPIO && gpio_rise[value_q[1:0]]);
    fire = state_q == ALIGN || (state_q == ARMED && cond);
    done = !accept && fire && update;
    state_d = accept ? ARMED : fire ? (update ? IDLE : ALIGN) : state_q;
    mode_d = accept ? req_mode : mode_q;
    value_d = accept ? req_value : value_q;
    tgt_d = accept ? req_segment : tgt_q;
    seg_d = done ? tgt_q : seg_q;
    swap_d = done && tgt_q != seg_q;
  end
  always_comb begin
    swap = swap_q;
    segment = seg_q;
    pending = state_q != IDLE;
  end
endmodule

// File: rtl/segment_transition_scheduler.sv
// segment_transition_scheduler: decodes transition requests and sequences MOD/STM segment swaps on UPDATE
module segment_transition_scheduler
  import transition::*;
#(
  parameter int GPIO_N = 4,
  parameter int SYS_TIME_W = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic [SYS_TIME_W-1:0] SYS_TIME,
  input  logic UPDATE,
  input  logic [GPIO_N-1:0] GPIO_IN,
  input  logic MOD_WRAP,
  input  logic STM_WRAP,
  segment_transition_scheduler_if.slave req,
  output logic MOD_SWAP,
  output logic MOD_SEGMENT,
  output logic STM_SWAP,
  output logic STM_SEGMENT,
  output logic [1:0] PENDING,
  output logic REQ_DROP,
  output logic ERR_LATE,
  output logic ERR_MODE
);
  logic [GPIO_N-1:0] g1_q, g1_d, g2_q, g2_d, g3_q, g3_d, rise;
  logic drop_q, drop_d, late_q, late_d, emode_q, emode_d;
  logic take, mode_ok, late;
  logic [1:0] acc, pend;
  mode_t req_mode;
  always_ff @(posedge CLK) begin
    g1_q <= RESET ? '0 : g1_d;
    g2_q <= RESET ? '0 : g2_d;
    g3_q <= RESET ? '0 : g3_d;
    drop_q <= RESET ? 1'b0 : drop_d;
    late_q <= RESET ? 1'b0 : late_d;
    emode_q <= RESET ? 1'b0 : emode_d;
  end
  always_comb begin
    g1_d = GPIO_IN;
    g2_d = g1_q;
    g3_d = g2_q;
    rise = g2_q & ~g3_q;
    take = req.REQ_VALID && req.REQ_READY;
    mode_ok = !req.REQ_MODE[2];
    req_mode = mode_t'(req.REQ_MODE);
    late = req_mode == transition::SYS_TIME && SYS_TIME >= req.REQ_VALUE;
    acc = {2{take && mode_ok && !late}} & {req.REQ_TARGET, !req.REQ_TARGET};
    drop_d = |(acc & pend);
    late_d = take && mode_ok && late;
    emode_d = take && !mode_ok;
  end
  always_comb begin
    req.REQ_READY = !RESET;
    PENDING = pend;
    REQ_DROP = drop_q;
    ERR_LATE = late_q;
    ERR_MODE = emode_q;
  end
  transition_channel #(.SYS_TIME_W(SYS_TIME_W), .GPIO_N(GPIO_N)) u_mod (
    .clk(CLK), .rst(RESET), .accept(acc[0]), .req_segment(req.REQ_SEGMENT), .req_mode(req_mode),
    .req_value(req.REQ_VALUE), .sys_time(SYS_TIME), .update(UPDATE), .wrap(MOD_WRAP), .gpio_rise(rise),
    .swap(MOD_SWAP), .segment(MOD_SEGMENT), .pending(pend[0])
  );
  transition_channel #(.SYS_TIME_W(SYS_TIME_W), .GPIO_N(GPIO_N)) u_stm (
    .clk(CLK), .rst(RESET), .accept(acc[1]), .req_segment(req.REQ_SEGMENT), .req_mode(req_mode),
    .req_value(req.REQ_VALUE), .sys_time(SYS_TIME), .update(UPDATE), .wrap(STM_WRAP), .gpio_rise(rise),
    .swap(STM_SWAP), .segment(STM_SEGMENT), .pending(pend[1])
  );
endmodule

// File: tb/tb_segment_transition_scheduler.sv
// tb_segment_transition_scheduler: directed and random stimulus checked against a request-level model
module tb_segment_transition_scheduler;
  localparam int TW = 64;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [TW-1:0] SYS_TIME = 64'd1000;
  logic UPDATE = 1'b0;
  logic MOD_WRAP = 1'b0;
  logic STM_WRAP = 1'b0;
  logic [3:0] GPIO_IN = 4'b0;
  logic MOD_SWAP, MOD_SEGMENT, STM_SWAP, STM_SEGMENT, REQ_DROP, ERR_LATE, ERR_MODE;
  logic [1:0] PENDING;
  int checks = 0;
  int errors = 0;
  bit [1:0] m_pend, m_fired, m_seg, m_cur, m_swap;
  bit [2:0] m_mode [2];
  logic [TW-1:0] m_val [2];
  bit m_drop, m_late, m_emode;
  bit [3:0] gh1, gh2, gh3;
  segment_transition_scheduler_if #(.SYS_TIME_W(TW)) req ();
  segment_transition_scheduler #(.GPIO_N(4), .SYS_TIME_W(TW)) dut (
    .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME), .UPDATE(UPDATE), .GPIO_IN(GPIO_IN),
    .MOD_WRAP(MOD_WRAP), .STM_WRAP(STM_WRAP), .req(req),
    .MOD_SWAP(MOD_SWAP), .MOD_SEGMENT(MOD_SEGMENT), .STM_SWAP(STM_SWAP), .STM_SEGMENT(STM_SEGMENT),
    .PENDING(PENDING), .REQ_DROP(REQ_DROP), .ERR_LATE(ERR_LATE), .ERR_MODE(ERR_MODE)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit [3:0] rise;
    bit [1:0] wr;
    bit take, go;
    rise = gh2 & ~gh3;
    wr = {STM_WRAP, MOD_WRAP};
    m_drop = 0;
    m_late = 0;
    m_emode = 0;
    m_swap = 0;
    if (RESET) begin
      m_pend = 0;
      m_cur = 0;
      {gh1, gh2, gh3} = 0;
      return;
    end
    gh3 = gh2;
    gh2 = gh1;
    gh1 = GPIO_IN;
    for (int ch = 0; ch < 2; ch++) begin
      take = req.REQ_VALID && int'(req.REQ_TARGET) == ch && req.REQ_MODE < 4 &&
             !(req.REQ_MODE == 2 && SYS_TIME >= req.REQ_VALUE);
      if (take) begin
        m_drop |= m_pend[ch];
        m_pend[ch] = 1;
        m_fired[ch] = 0;
        m_mode[ch] = req.REQ_MODE;
        m_val[ch] = req.REQ_VALUE;
        m_seg[ch] = req.REQ_SEGMENT;
      end else if (m_pend[ch]) begin
        go = m_fired[ch] || m_mode[ch] == 0 || (m_mode[ch] == 1 && wr[ch]) ||
             (m_mode[ch] == 2 && SYS_TIME >= m_val[ch]) || (m_mode[ch] == 3 && rise[m_val[ch][1:0]]);
        if (go && UPDATE) begin
          m_pend[ch] = 0;
          if (m_seg[ch] != m_cur[ch]) begin
            m_cur[ch] = m_seg[ch];
            m_swap[ch] = 1;
          end
        end else m_fired[ch] = go;
      end
    end
    if (req.REQ_VALID) begin
      m_emode = req.REQ_MODE >= 4;
      m_late = req.REQ_MODE == 2 && SYS_TIME >= req.REQ_VALUE;
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check("mod_swap", MOD_SWAP, m_swap[0]);
    check("stm_swap", STM_SWAP, m_swap[1]);
    check("mod_seg", MOD_SEGMENT, m_cur[0]);
    check("stm_seg", STM_SEGMENT, m_cur[1]);
    check("pending", PENDING, m_pend);
    check("req_drop", REQ_DROP, m_drop);
    check("err_late", ERR_LATE, m_late);
    check("err_mode", ERR_MODE, m_emode);
    check("req_ready", req.REQ_READY, !RESET);
    req.REQ_VALID = 0;
    UPDATE = 0;
    MOD_WRAP = 0;
    STM_WRAP = 0;
    SYS_TIME = SYS_TIME + 1;
  endtask
  task automatic send(input bit tgt, input bit seg, input bit [2:0] mode, input logic [TW-1:0] val);
    req.REQ_VALID = 1;
    req.REQ_TARGET = tgt;
    req.REQ_SEGMENT = seg;
    req.REQ_MODE = mode;
    req.REQ_VALUE = val;
    tick();
  endtask
  initial begin
    int r;
    req.REQ_VALID = 0;
    req.REQ_TARGET = 0;
    req.REQ_SEGMENT = 0;
    req.REQ_MODE = 0;
    req.REQ_VALUE = 0;
    repeat (3) tick();
    check("rst_ready", req.REQ_READY, 0);
    RESET = 0;
    tick();
    send(0, 1, 0, 0);
    repeat (4) tick();
    UPDATE = 1;
    tick();
    check("imm_swap", MOD_SWAP, 1);
    check("imm_seg", MOD_SEGMENT, 1);
    check("imm_stm", STM_SWAP, 0);
    tick();
    check("imm_once", MOD_SWAP, 0);
    send(0, 0, 2, SYS_TIME + 100);
    repeat (15) begin
      repeat (9) tick();
      UPDATE = 1;
      tick();
    end
    check("time_done", MOD_SEGMENT, 0);
    send(1, 1, 2, SYS_TIME - 5);
    check("late_err", ERR_LATE, 1);
    check("late_pend", PENDING, 0);
    STM_WRAP = 1;
    tick();
    send(1, 1, 1, 0);
    repeat (6) tick();
    STM_WRAP = 1;
    tick();
    repeat (4) tick();
    check("sync_wait", STM_SWAP, 0);
    UPDATE = 1;
    tick();
    check("sync_swap", STM_SWAP, 1);
    GPIO_IN = 4'b0100;
    repeat (4) tick();
    send(0, 1, 3, 2);
    repeat (3) begin
      repeat (4) tick();
      UPDATE = 1;
      tick();
    end
    check("gpio_held", PENDING, 2'b01);
    GPIO_IN = 4'b0000;
    repeat (4) tick();
    GPIO_IN = 4'b0100;
    repeat (4) tick();
    UPDATE = 1;
    tick();
    check("gpio_swap", MOD_SWAP, 1);
    send(0, 0, 2, SYS_TIME + 1000);
    send(0, 0, 0, 0);
    check("drop", REQ_DROP, 1);
    send(0, 1, 5, 0);
    check("mode_err", ERR_MODE, 1);
    check("mode_keep", PENDING, 2'b01);
    UPDATE = 1;
    tick();
    check("ovr_swap", MOD_SWAP, 1);
    check("ovr_seg", MOD_SEGMENT, 0);
    send(0, 1, 0, 0);
    send(1, 0, 0, 0);
    UPDATE = 1;
    tick();
    check("both_mod", MOD_SWAP, 1);
    check("both_stm", STM_SWAP, 1);
    send(0, 0, 2, SYS_TIME + 1000);
    send(1, 1, 1, 0);
    RESET = 1;
    tick();
    check("rst_mod", MOD_SEGMENT, 0);
    check("rst_pend", PENDING, 0);
    check("rst_swap", MOD_SWAP, 0);
    RESET = 0;
    repeat (3000) begin
      RESET = $urandom_range(0, 299) == 0;
      UPDATE = $urandom_range(0, 5) == 0;
      MOD_WRAP = $urandom_range(0, 7) == 0;
      STM_WRAP = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 9) == 0) GPIO_IN = GPIO_IN ^ (4'b1 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        r = int'($urandom_range(0, 9));
        req.REQ_VALID = 1;
        req.REQ_TARGET = 1'($urandom_range(0, 1));
        req.REQ_SEGMENT = 1'($urandom_range(0, 1));
        req.REQ_MODE = r < 8 ? 3'(r % 4) : 3'(4 + $urandom_range(0, 3));
        req.REQ_VALUE = req.REQ_MODE == 2 ? SYS_TIME + 64'($urandom_range(0, 40)) - 64'd8
                                          : 64'($urandom_range(0, 3));
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
